// File: rtl/FIR_pkg.sv
// Shared definitions for the FIR estimator MCA blocks: FSM state encoding
// and small elaboration-time helpers for width derivation.
package FIR_pkg;

  typedef enum logic [0:0] {
    MCA_IDLE   = 1'b0,
    MCA_ADDING = 1'b1
  } state_mca_e;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mca_lut_lane_sum.sv
// Combinational lane stage: LANES LUT lookups for the current counter value,
// sign-extended and summed; lanes past the last group contribute zero.
module mca_lut_lane_sum
  import FIR_pkg::*;
#(
  parameter int WIDTH_COEFFICIENT = 32,
  parameter int NUM_GROUPS        = 16,
  parameter int LUT_BITS          = 3,
  parameter int LANES             = 2,
  parameter int CNT_W             = 3,
  parameter int WIDTH_ACC         = 37
) (
  input  logic        [CNT_W-1:0]                 counter,
  input  logic        [NUM_GROUPS*LUT_BITS-1:0]   s_reg,
  input  logic signed [WIDTH_COEFFICIENT-1:0]     lut [NUM_GROUPS*(2**LUT_BITS)],
  output logic signed [WIDTH_ACC-1:0]             lane_sum
);

  localparam int GRP_W = max_int(1, $clog2(NUM_GROUPS));
  localparam int IDX_W = max_int(1, $clog2(NUM_GROUPS * (2**LUT_BITS)));
  localparam int EXT_W = WIDTH_ACC - WIDTH_COEFFICIENT;

  logic        [LUT_BITS-1:0]  sel      [NUM_GROUPS];
  logic signed [WIDTH_ACC-1:0] lane_val [LANES];

  genvar gi;
  for (gi = 0; gi < NUM_GROUPS; gi++) begin : g_sel
    assign sel[gi] = s_reg[gi*LUT_BITS +: LUT_BITS];
  end

  for (gi = 0; gi < LANES; gi++) begin : g_lane
    logic        [31:0]                  grp;
    logic                                grp_valid;
    logic        [GRP_W-1:0]             grp_safe;
    logic        [IDX_W-1:0]             idx;
    logic signed [WIDTH_COEFFICIENT-1:0] entry;

    assign grp       = 32'(counter) * 32'(LANES) + 32'(gi);
    assign grp_valid = (grp < 32'(NUM_GROUPS));
    // Out-of-range groups are steered to group 0 so the mux index stays legal.
    assign grp_safe  = grp_valid ? grp[GRP_W-1:0] : '0;
    assign idx       = IDX_W'({grp_safe, sel[grp_safe]});
    assign entry     = lut[idx];
    assign lane_val[gi] = grp_valid ? {{EXT_W{entry[WIDTH_COEFFICIENT-1]}}, entry} : '0;
  end

  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_sum = lane_sum + lane_val[k];
    end
  end

endmodule

// File: rtl/mca_lut_multilane.sv
// Multi-cycle LUT accumulator: LANES lookups per enabled cycle, C cycles per
// result, with back-to-back restart on the last cycle and optional saturation.
module mca_lut_multilane
  import FIR_pkg::*;
#(
  parameter int WIDTH_COEFFICIENT = 32,
  parameter int WIDTH_OUT         = 32,
  parameter int NUM_GROUPS        = 16,
  parameter int LUT_BITS          = 3,
  parameter int LANES             = 2,
  parameter int SATURATE          = 1
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 enable,
  input  logic                                 start,
  input  logic signed [WIDTH_COEFFICIENT-1:0]  lut [NUM_GROUPS*(2**LUT_BITS)],
  input  logic        [NUM_GROUPS*LUT_BITS-1:0] S_values,
  output logic                                 busy,
  output logic                                 res_valid,
  output logic signed [WIDTH_OUT-1:0]          res,
  output logic                                 sat,
  output logic                                 overrun
);

  localparam int C         = ceil_div(NUM_GROUPS, LANES);
  localparam int CNT_W     = max_int(1, $clog2(C));
  localparam int WIDTH_ACC = WIDTH_COEFFICIENT + $clog2(NUM_GROUPS) + 1;
  localparam int WX        = max_int(WIDTH_ACC, WIDTH_OUT);

  localparam logic        [CNT_W-1:0] CNT_LAST = CNT_W'(C - 1);
  localparam logic signed [WX-1:0]    SAT_MAX  = {{(WX-WIDTH_OUT+1){1'b0}}, {(WIDTH_OUT-1){1'b1}}};
  localparam logic signed [WX-1:0]    SAT_MIN  = {{(WX-WIDTH_OUT+1){1'b1}}, {(WIDTH_OUT-1){1'b0}}};

  state_mca_e                         state_q, state_d;
  logic        [CNT_W-1:0]            count_q, count_d;
  logic signed [WIDTH_ACC-1:0]        acc_q, acc_d;
  logic        [NUM_GROUPS*LUT_BITS-1:0] s_q, s_d;
  logic signed [WIDTH_OUT-1:0]        res_q, res_d;
  logic                               res_valid_q, res_valid_d;
  logic                               sat_q, sat_d;
  logic                               overrun_q, overrun_d;

  logic signed [WIDTH_ACC-1:0]        lane_sum;
  logic signed [WIDTH_ACC-1:0]        total;
  logic signed [WX-1:0]               total_x;
  logic signed [WIDTH_OUT-1:0]        res_next;
  logic                               sat_next;

  mca_lut_lane_sum #(
    .WIDTH_COEFFICIENT (WIDTH_COEFFICIENT),
    .NUM_GROUPS        (NUM_GROUPS),
    .LUT_BITS          (LUT_BITS),
    .LANES             (LANES),
    .CNT_W             (CNT_W),
    .WIDTH_ACC         (WIDTH_ACC)
  ) u_lane_sum (
    .counter  (count_q),
    .s_reg    (s_q),
    .lut      (lut),
    .lane_sum (lane_sum)
  );

  assign total   = acc_q + lane_sum;
  assign total_x = WX'(total);

  always_comb begin
    res_next = total_x[WIDTH_OUT-1:0];
    sat_next = 1'b0;
    if (SATURATE != 0) begin
      if (total_x > SAT_MAX) begin
        res_next = SAT_MAX[WIDTH_OUT-1:0];
        sat_next = 1'b1;
      end else if (total_x < SAT_MIN) begin
        res_next = SAT_MIN[WIDTH_OUT-1:0];
        sat_next = 1'b1;
      end
    end
  end

  // Pulses default low every cycle so they clear even while enable is low.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    s_d         = s_q;
    res_d       = res_q;
    res_valid_d = 1'b0;
    sat_d       = 1'b0;
    overrun_d   = 1'b0;
    if (enable) begin
      case (state_q)
        MCA_IDLE: begin
          if (start) begin
            state_d = MCA_ADDING;
            s_d     = S_values;
            count_d = '0;
            acc_d   = '0;
          end
        end
        MCA_ADDING: begin
          if (count_q != CNT_LAST) begin
            count_d   = count_q + CNT_W'(1);
            acc_d     = total;
            overrun_d = start;
          end else begin
            res_d       = res_next;
            sat_d       = sat_next;
            res_valid_d = 1'b1;
            count_d     = '0;
            acc_d       = '0;
            if (start) begin
              s_d = S_values;
            end else begin
              state_d = MCA_IDLE;
            end
          end
        end
        default: state_d = MCA_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= MCA_IDLE;
      count_q     <= '0;
      acc_q       <= '0;
      s_q         <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      s_q         <= s_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      sat_q       <= sat_d;
      overrun_q   <= overrun_d;
    end
  end

  assign busy      = (state_q == MCA_ADDING);
  assign res_valid = res_valid_q;
  assign res       = res_q;
  assign sat       = sat_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_mca_lut_multilane.sv
// Directed bench for mca_lut_multilane: 16-group saturating and wrapping
// instances plus a 5-group instance for the partial last cycle.
module tb_mca_lut_multilane;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn, enable;
  logic start_ab, start_c;
  logic [47:0] s_ab;
  logic [14:0] s_c;
  logic signed [31:0] lut_a [128];
  logic signed [31:0] lut_w [128];
  logic signed [31:0] lut_c [40];

  logic busy_a, res_valid_a, sat_a, overrun_a;
  logic busy_w, res_valid_w, sat_w, overrun_w;
  logic busy_c, res_valid_c, sat_c, overrun_c;
  logic signed [31:0] res_a, res_w, res_c;

  int errors = 0;
  int checks = 0;

  mca_lut_multilane #(.WIDTH_COEFFICIENT(32), .WIDTH_OUT(32), .NUM_GROUPS(16),
                      .LUT_BITS(3), .LANES(2), .SATURATE(1)) dut_a (
    .clk(clk), .resetn(resetn), .enable(enable), .start(start_ab),
    .lut(lut_a), .S_values(s_ab), .busy(busy_a), .res_valid(res_valid_a),
    .res(res_a), .sat(sat_a), .overrun(overrun_a));

  mca_lut_multilane #(.WIDTH_COEFFICIENT(32), .WIDTH_OUT(32), .NUM_GROUPS(16),
                      .LUT_BITS(3), .LANES(2), .SATURATE(0)) dut_w (
    .clk(clk), .resetn(resetn), .enable(enable), .start(start_ab),
    .lut(lut_w), .S_values(s_ab), .busy(busy_w), .res_valid(res_valid_w),
    .res(res_w), .sat(sat_w), .overrun(overrun_w));

  mca_lut_multilane #(.WIDTH_COEFFICIENT(32), .WIDTH_OUT(32), .NUM_GROUPS(5),
                      .LUT_BITS(3), .LANES(2), .SATURATE(1)) dut_c (
    .clk(clk), .resetn(resetn), .enable(enable), .start(start_c),
    .lut(lut_c), .S_values(s_c), .busy(busy_c), .res_valid(res_valid_c),
    .res(res_c), .sat(sat_c), .overrun(overrun_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_ramp();
    for (int g = 0; g < 16; g++)
      for (int v = 0; v < 8; v++)
        lut_a[g*8+v] = 32'(8*g + v);
    for (int g = 0; g < 5; g++)
      for (int v = 0; v < 8; v++)
        lut_c[g*8+v] = 32'(8*g + v);
    for (int i = 0; i < 128; i++) lut_w[i] = 32'sd0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b1; start_ab = 1'b0; start_c = 1'b0;
    s_ab = '0; s_c = '0;
    fill_ramp();
    tick(); tick();
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    checks++; if (res_valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", res_valid_a); end
    checks++; if (res_a !== 32'sd0) begin errors++; $display("FAIL reset_res: got %0d want 0", res_a); end
    checks++; if ({sat_a, overrun_a, sat_w, res_valid_c} !== 4'b0) begin errors++; $display("FAIL reset_pulses: got %b want 0000", {sat_a, overrun_a, sat_w, res_valid_c}); end
    checks++; if (res_w !== 32'sd0 || res_c !== 32'sd0) begin errors++; $display("FAIL reset_res_other: got %0d/%0d want 0/0", res_w, res_c); end
    resetn = 1'b1;
    tick();
    $display("test_reset: busy=%b res=%0d", busy_a, res_a);
  endtask

  task automatic test_basic();
    int busy_cnt, valid_cnt, valid_at;
    logic signed [31:0] res_seen;
    s_ab = {16{3'b101}};
    start_ab = 1'b1; tick(); start_ab = 1'b0;
    busy_cnt = busy_a ? 1 : 0; valid_cnt = 0; valid_at = -1; res_seen = '0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (busy_a) busy_cnt++;
      if (res_valid_a) begin valid_cnt++; valid_at = i; res_seen = res_a; end
    end
    checks++; if (valid_cnt != 1) begin errors++; $display("FAIL basic_valid_count: got %0d want 1", valid_cnt); end
    checks++; if (valid_at != 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", valid_at); end
    checks++; if (res_seen !== 32'sd1040) begin errors++; $display("FAIL basic_res: got %0d want 1040", res_seen); end
    checks++; if (busy_cnt != 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 8", busy_cnt); end
    checks++; if (res_a !== 32'sd1040) begin errors++; $display("FAIL basic_res_hold: got %0d want 1040", res_a); end
    $display("test_basic: res=%0d latency=%0d busy_cycles=%0d", res_seen, valid_at, busy_cnt);
  endtask

  task automatic test_back_to_back();
    int valid_cnt, valid_at, busy_low;
    logic signed [31:0] res_seen;
    s_ab = {16{3'b101}};
    start_ab = 1'b1; tick(); start_ab = 1'b0;
    busy_low = 0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (!busy_a) busy_low++;
    end
    start_ab = 1'b1; s_ab = '0;
    tick();
    start_ab = 1'b0;
    checks++; if (res_valid_a !== 1'b1 || res_a !== 32'sd1040) begin errors++; $display("FAIL b2b_first: got valid=%b res=%0d want valid=1 res=1040", res_valid_a, res_a); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL b2b_no_idle: got busy=%b want 1", busy_a); end
    valid_cnt = 0; valid_at = -1; res_seen = '0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i < 8 && !busy_a) busy_low++;
      if (res_valid_a) begin valid_cnt++; valid_at = i; res_seen = res_a; end
    end
    checks++; if (valid_cnt != 1 || valid_at != 8) begin errors++; $display("FAIL b2b_second_timing: got count=%0d at=%0d want count=1 at=8", valid_cnt, valid_at); end
    checks++; if (res_seen !== 32'sd960) begin errors++; $display("FAIL b2b_second_res: got %0d want 960", res_seen); end
    checks++; if (busy_low != 0) begin errors++; $display("FAIL b2b_busy: got %0d idle cycles want 0", busy_low); end
    $display("test_back_to_back: res2=%0d spacing=%0d", res_seen, valid_at);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 128; i++) begin
      lut_a[i] = 32'sh7FFF_FFFF;
      lut_w[i] = 32'sh7FFF_FFFF;
    end
    s_ab = {16{3'b011}};
    start_ab = 1'b1; tick(); start_ab = 1'b0;
    for (int i = 1; i <= 8; i++) tick();
    checks++; if (res_valid_a !== 1'b1 || res_a !== 32'sh7FFF_FFFF) begin errors++; $display("FAIL sat_res: got valid=%b res=%h want valid=1 res=7fffffff", res_valid_a, res_a); end
    checks++; if (sat_a !== 1'b1) begin errors++; $display("FAIL sat_flag: got %b want 1", sat_a); end
    checks++; if (res_valid_w !== 1'b1 || res_w !== 32'shFFFF_FFF0) begin errors++; $display("FAIL wrap_res: got valid=%b res=%h want valid=1 res=fffffff0", res_valid_w, res_w); end
    checks++; if (sat_w !== 1'b0) begin errors++; $display("FAIL wrap_sat_flag: got %b want 0", sat_w); end
    tick();
    checks++; if (sat_a !== 1'b0 || res_valid_a !== 1'b0) begin errors++; $display("FAIL sat_pulse_clear: got sat=%b valid=%b want 0/0", sat_a, res_valid_a); end
    $display("test_saturation: sat_res=%h wrap_res=%h", res_a, res_w);
    fill_ramp();
  endtask

  task automatic test_enable_stall();
    int valid_cnt, valid_at, ovr_cnt;
    logic signed [31:0] res_seen;
    s_ab = {16{3'b101}};
    start_ab = 1'b1; tick(); start_ab = 1'b0;
    valid_cnt = 0; valid_at = -1; ovr_cnt = 0; res_seen = '0;
    for (int i = 1; i <= 14; i++) begin
      if (i >= 5 && i <= 7) begin enable = 1'b0; start_ab = 1'b1; end
      else begin enable = 1'b1; start_ab = 1'b0; end
      tick();
      if (overrun_a) ovr_cnt++;
      if (res_valid_a) begin valid_cnt++; valid_at = i; res_seen = res_a; end
    end
    enable = 1'b1; start_ab = 1'b0;
    checks++; if (valid_cnt != 1 || valid_at != 11) begin errors++; $display("FAIL stall_latency: got count=%0d at=%0d want count=1 at=11", valid_cnt, valid_at); end
    checks++; if (res_seen !== 32'sd1040) begin errors++; $display("FAIL stall_res: got %0d want 1040", res_seen); end
    checks++; if (ovr_cnt != 0) begin errors++; $display("FAIL stall_overrun: got %0d pulses want 0", ovr_cnt); end
    $display("test_enable_stall: res=%0d latency=%0d", res_seen, valid_at);
  endtask

  task automatic test_reset_mid();
    int valid_cnt, valid_at;
    logic signed [31:0] res_seen;
    s_ab = {16{3'b101}};
    start_ab = 1'b1; tick(); start_ab = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    resetn = 1'b0;
    #1;
    checks++; if (busy_a !== 1'b0 || res_a !== 32'sd0) begin errors++; $display("FAIL rstmid_outputs: got busy=%b res=%0d want 0/0", busy_a, res_a); end
    checks++; if ({res_valid_a, sat_a, overrun_a} !== 3'b000) begin errors++; $display("FAIL rstmid_pulses: got %b want 000", {res_valid_a, sat_a, overrun_a}); end
    tick();
    resetn = 1'b1;
    valid_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (res_valid_a) valid_cnt++;
    end
    checks++; if (valid_cnt != 0 || busy_a !== 1'b0) begin errors++; $display("FAIL rstmid_no_result: got valid_count=%0d busy=%b want 0/0", valid_cnt, busy_a); end
    start_ab = 1'b1; tick(); start_ab = 1'b0;
    valid_at = -1; res_seen = '0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (res_valid_a) begin valid_at = i; res_seen = res_a; end
    end
    checks++; if (valid_at != 8 || res_seen !== 32'sd1040) begin errors++; $display("FAIL rstmid_restart: got at=%0d res=%0d want at=8 res=1040", valid_at, res_seen); end
    $display("test_reset_mid: restart res=%0d", res_seen);
  endtask

  task automatic test_odd_lane();
    int valid_cnt, valid_at, ovr_at, ovr_cnt, busy_bad;
    logic signed [31:0] res_seen;
    s_c = {5{3'b001}};
    start_c = 1'b1; tick(); start_c = 1'b0;
    valid_cnt = 0; valid_at = -1; ovr_at = -1; ovr_cnt = 0; busy_bad = 0; res_seen = '0;
    for (int i = 1; i <= 6; i++) begin
      start_c = (i == 2);
      tick();
      if (busy_c !== (i < 3)) busy_bad++;
      if (overrun_c) begin ovr_cnt++; ovr_at = i; end
      if (res_valid_c) begin valid_cnt++; valid_at = i; res_seen = res_c; end
    end
    start_c = 1'b0;
    checks++; if (valid_cnt != 1 || valid_at != 3) begin errors++; $display("FAIL odd_latency: got count=%0d at=%0d want count=1 at=3", valid_cnt, valid_at); end
    checks++; if (res_seen !== 32'sd85) begin errors++; $display("FAIL odd_res: got %0d want 85", res_seen); end
    checks++; if (ovr_cnt != 1 || ovr_at != 2) begin errors++; $display("FAIL odd_overrun: got count=%0d at=%0d want count=1 at=2", ovr_cnt, ovr_at); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL odd_busy: got %0d wrong cycles want 0", busy_bad); end
    $display("test_odd_lane: res=%0d latency=%0d overrun_at=%0d", res_seen, valid_at, ovr_at);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturation();
    test_enable_stall();
    test_reset_mid();
    test_odd_lane();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mca_lut_multilane.md
# mca_lut_multilane

Parametrised multi-cycle LUT accumulator for the FIR digital estimator: `LANES` LUT lookups are summed per clock until all `NUM_GROUPS` lookups are accumulated into one result. Each lookup takes `LUT_BITS` control bits and selects one of 2^`LUT_BITS` precomputed coefficient sums.

Compared with the fixed 16-addition, 3-bit-LUT block, it adds:
- a configurable LUT size, lane count and group count;
- a captured control word;
- back-to-back starts;
- a `res_valid`/`busy` handshake;
- optional output saturation.

## Interface
- `WIDTH_COEFFICIENT`, 32, width of each signed LUT entry
- `WIDTH_OUT`, 32, width of the signed result
- `NUM_GROUPS`, 16, LUT lookups per result (≥1)
- `LUT_BITS`, 3, control bits per lookup; each group has 2^`LUT_BITS` entries
- `LANES`, 2, lookups summed per cycle (1..`NUM_GROUPS`)
- `SATURATE`, 1, 1 = clamp result to `WIDTH_OUT`, 0 = wrap (keep low bits)
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- enable  in  1  clock enable; low freezes all state except the `res_valid`/`sat`/`overrun` pulse clear
- start  in  1  request a new accumulation
- lut  in  signed [`WIDTH_COEFFICIENT`-1:0] x [`NUM_GROUPS`*2^`LUT_BITS`]  group g entry v at index g*2^`LUT_BITS`+v; must be static during an accumulation
- S_values  in  [`NUM_GROUPS`*`LUT_BITS`-1:0]  group g selector at bits [g*`LUT_BITS` +: `LUT_BITS`]
- busy  out  1  state is MCA_ADDING
- res_valid  out  1  one-cycle pulse when `res` updates
- res  out  signed [`WIDTH_OUT`-1:0]  last result; holds until the next update
- sat  out  1  pulse with `res_valid` when clamping occurred
- overrun  out  1  one-cycle pulse when `start` is rejected

## Operation
- **Derived constants:**
  - C = ceil(`NUM_GROUPS`/`LANES`), the number of ADDING cycles.
  - Counter width = max(1, clog2(C)).
  - Accumulator width `WIDTH_ACC` = `WIDTH_COEFFICIENT` + clog2(`NUM_GROUPS`) + 1.
  - Summation is exact and sign-extended.
- **States:** MCA_IDLE, MCA_ADDING.
- **Transitions** (all require `enable`=1):
  - IDLE & `start` → ADDING. At this edge: capture `S_values` into `s_reg`, counter=0, acc=0.
  - ADDING & counter<C-1 → ADDING, counter+1.
  - ADDING & counter==C-1 & `start` → ADDING. Recapture `s_reg`, counter=0, acc=0.
  - ADDING & counter==C-1 & !`start` → IDLE.
- **Per ADDING cycle:** lane k covers group g = counter*`LANES`+k.
  - If g<`NUM_GROUPS`, the lane adds lut[g*2^`LUT_BITS` + s_reg[g]].
  - Otherwise the lane contributes 0, so a partial last cycle is padded with zeros.
  - lane_sum is added into acc.
- **Last cycle:** total = acc + lane_sum.
  - With `SATURATE`=1, total is clamped to [-2^(`WIDTH_OUT`-1), 2^(`WIDTH_OUT`-1)-1], and `sat`=1 if clamped.
  - With `SATURATE`=0, the low `WIDTH_OUT` bits are kept and `sat`=0.
  - `res` is registered at this edge; `res_valid`=1.
- **`start` during ADDING, not on the last cycle:** ignored and pulses `overrun`. The computation in flight is unaffected.
- **`start` while `enable`=0:** ignored, with no `overrun`.

## Timing
- **Reset values:** state IDLE, counter 0, acc 0, `s_reg` 0, `res` 0, `busy` 0, `res_valid` 0, `sat` 0, `overrun` 0.
- **Latency:** `start` sampled at edge t0 → `res`/`res_valid` update at edge t0+C.
- **Throughput:** one result per C enabled cycles when `start` is held or re-asserted on the last cycle.
- **Pulse clearing:** `res_valid`, `sat` and `overrun` are high for exactly one clk cycle. They clear at the next posedge regardless of `enable`.
- **`enable` low for N cycles mid-operation:** completion is delayed by N cycles and the result is unchanged.
- **Reset mid-operation:** the accumulation is aborted, no `res_valid` is produced, and `res` returns to 0.

## Structure
- The state enum `state_mca_e` (MCA_IDLE, MCA_ADDING) lives in FIR_pkg and is shared with the existing MCA blocks.
- Width-derivation constants are computed locally from the parameters.
- Sub-module `mca_lut_lane_sum`: a combinational block that takes counter, `s_reg` and `lut` and produces lane_sum (`LANES` muxes plus an adder tree, with zero padding).
- The top level holds the FSM, counter, accumulator, saturation logic and output registers.

## Test plan
1. **Basic accumulation.** Config: `NUM_GROUPS`=16, `LANES`=2, `LUT_BITS`=3, lut[g][v]=8g+v. Stimulus: all selectors 3'b101, single `start`. Required: `res`=1040 and a single `res_valid` pulse exactly 8 cycles after `start`; `busy` is high for 8 cycles.
2. **Back-to-back starts.** Stimulus: as scenario 1, with `start` re-asserted on the last cycle and `S_values` changed to all 0. Required: results 1040 then 960, with `res_valid` pulses 8 cycles apart and no IDLE cycle in between.
3. **Saturation.** Stimulus: all lut=0x7FFFFFFF. Required: with `SATURATE`=1, `res`=0x7FFFFFFF and `sat`=1. With `SATURATE`=0, `res`=0xFFFFFFF0 and `sat`=0.
4. **Clock-enable stall.** Stimulus: `enable` deasserted for 3 cycles at counter=4. Required: `res_valid` arrives 11 cycles after `start`, `res`=1040, and the stalled `start` produces no `overrun`.
5. **Reset mid-operation.** Stimulus: `resetn` pulsed at counter=4. Required: all outputs return to 0 immediately and no `res_valid` is produced. A following `start` yields 1040.
6. **Odd lane split and overrun.** Config: `NUM_GROUPS`=5, `LANES`=2, lut[g][v]=8g+v, selectors 3'b001. Required: C=3 and `res`=85. A `start` at counter=1 pulses `overrun` for one cycle and the result is unaffected.
